// File: rtl/sm83_pkg.sv
// Shared types and constants for the SM83 interrupt controller slice.
// Contents:
//   ctl_op_t    - decoded control op retired by the core (EI/DI/RETI/HALT)
//   irq_idx_t   - 3-bit interrupt source index (0 = VBlank ... 4 = Joypad)
//   irq_state_t - controller FSM states
//   IRQ_VEC_BASE / IRQ_VEC_STRIDE - dispatch vector = base + stride * index
package sm83_pkg;

  typedef enum logic [2:0] {
    CTL_NOP  = 3'd0,
    CTL_EI   = 3'd1,
    CTL_DI   = 3'd2,
    CTL_RETI = 3'd3,
    CTL_HALT = 3'd4
  } ctl_op_t;

  typedef logic [2:0] irq_idx_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HALT     = 2'd1,
    ST_DISPATCH = 2'd2
  } irq_state_t;

  localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
  localparam logic [15:0] IRQ_VEC_STRIDE = 16'd8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for the five interrupt sources.
// Ports:
//   pending - IE & IF, one bit per source
//   valid   - at least one source pending
//   idx     - index of the lowest set bit (bit0 / VBlank wins)
module irq_prio_enc
  import sm83_pkg::*;
(
  input  logic [4:0] pending,
  output logic       valid,
  output irq_idx_t   idx
);

  // Lower bit numbers have higher priority, so test them first.
  always_comb begin
    valid = |pending;
    idx   = 3'd0;
    if (pending[0])      idx = 3'd0;
    else if (pending[1]) idx = 3'd1;
    else if (pending[2]) idx = 3'd2;
    else if (pending[3]) idx = 3'd3;
    else if (pending[4]) idx = 3'd4;
  end

endmodule

// File: rtl/irq_ctl.sv
// SM83-style interrupt controller: IF/IE registers, master enable (IME)
// with the EI delay slot, HALT handling and vectored dispatch handshake.
// Ports:
//   clk, rst              - clock, async active-high reset
//   irq_src[4:0]          - one-cycle request pulses (VBlank..Joypad)
//   reg_wdata, if_wr, ie_wr - register write port for IF / IE
//   if_rdata, ie_rdata    - register read-back ({3'b111, IF}, IE)
//   ctl_op, ctl_valid     - retired control instruction from the core
//   int_req, int_ack      - dispatch request / acceptance
//   int_done              - core finished jumping to the vector
//   int_vector            - dispatch target while dispatching, else 0
//   halted, wake          - HALT status and one-cycle HALT exit pulse
module irq_ctl
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  irq_src,
  input  logic [7:0]  reg_wdata,
  input  logic        if_wr,
  input  logic        ie_wr,
  output logic [7:0]  if_rdata,
  output logic [7:0]  ie_rdata,
  input  ctl_op_t     ctl_op,
  input  logic        ctl_valid,
  output logic        int_req,
  input  logic        int_ack,
  input  logic        int_done,
  output logic [15:0] int_vector,
  output logic        halted,
  output logic        wake
);

  logic [4:0] if_q;
  logic [7:0] ie_q;
  logic       ime_q;
  logic       ei_pend_q;
  irq_state_t state_q;
  irq_idx_t   idx_q;
  logic       wake_q;

  logic [4:0] pending;
  logic       pend_valid;
  irq_idx_t   win_idx;
  logic       accept;
  logic [4:0] ack_clr;
  logic [4:0] if_next;

  assign pending = ie_q[4:0] & if_q;

  irq_prio_enc u_prio (
    .pending (pending),
    .valid   (pend_valid),
    .idx     (win_idx)
  );

  // Request is held back while the EI delay slot is still open, so the
  // instruction after EI always retires before a dispatch can start.
  assign int_req = (state_q == ST_RUN) & ime_q & ~ei_pend_q & pend_valid;
  assign accept  = int_req & int_ack;

  // The acknowledged source is cleared from IF, but a fresh pulse on the
  // same bit in the same cycle wins so no request is ever lost.
  always_comb begin
    ack_clr = 5'b00000;
    if (accept) ack_clr = 5'b00001 << win_idx;
    if_next = ((if_wr ? reg_wdata[4:0] : if_q) & ~ack_clr) | irq_src;
  end

  // Main controller state: registers, IME/EI bookkeeping and the
  // RUN/HALT/DISPATCH sequencing. Control ops are only honoured in RUN;
  // an accepted dispatch is applied last so it always leaves IME cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_q      <= 5'b00000;
      ie_q      <= 8'h00;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      state_q   <= ST_RUN;
      idx_q     <= 3'd0;
      wake_q    <= 1'b0;
    end else begin
      if_q   <= if_next;
      wake_q <= 1'b0;
      if (ie_wr) ie_q <= reg_wdata;
      case (state_q)
        ST_RUN: begin
          if (ctl_valid) begin
            if (ctl_op == CTL_DI) begin
              ime_q     <= 1'b0;
              ei_pend_q <= 1'b0;
            end else begin
              if (ei_pend_q) begin
                ime_q     <= 1'b1;
                ei_pend_q <= 1'b0;
              end
              case (ctl_op)
                CTL_EI:   if (!ime_q && !ei_pend_q) ei_pend_q <= 1'b1;
                CTL_RETI: ime_q <= 1'b1;
                CTL_HALT: if (!pend_valid) state_q <= ST_HALT;
                default:  ;
              endcase
            end
          end
          if (accept) begin
            idx_q   <= win_idx;
            ime_q   <= 1'b0;
            state_q <= ST_DISPATCH;
          end
        end
        ST_HALT: begin
          if (pend_valid) begin
            state_q <= ST_RUN;
            wake_q  <= 1'b1;
          end
        end
        ST_DISPATCH: begin
          if (int_done) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    int_vector = 16'h0000;
    if (state_q == ST_DISPATCH)
      int_vector = IRQ_VEC_BASE + IRQ_VEC_STRIDE * {13'd0, idx_q};
  end

  assign halted   = (state_q == ST_HALT);
  assign wake     = wake_q;
  assign if_rdata = {3'b111, if_q};
  assign ie_rdata = ie_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed vector table, hand-written
// multi-cycle sequences (async reset mid-dispatch, HALT wake with IME=1),
// and randomized traffic against a behavioural reference model.
module tb_irq_ctl;
  import sm83_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_src;
  logic [7:0]  reg_wdata;
  logic        if_wr, ie_wr;
  logic [7:0]  if_rdata, ie_rdata;
  ctl_op_t     ctl_op;
  logic        ctl_valid;
  logic        int_req, int_ack, int_done;
  logic [15:0] int_vector;
  logic        halted, wake;

  int checks = 0;
  int errors = 0;

  irq_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .reg_wdata  (reg_wdata),
    .if_wr      (if_wr),
    .ie_wr      (ie_wr),
    .if_rdata   (if_rdata),
    .ie_rdata   (ie_rdata),
    .ctl_op     (ctl_op),
    .ctl_valid  (ctl_valid),
    .int_req    (int_req),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .int_vector (int_vector),
    .halted     (halted),
    .wake       (wake)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  src;
    logic [7:0]  wdata;
    logic        ifw;
    logic        iew;
    ctl_op_t     op;
    logic        valid;
    logic        ack;
    logic        done;
    logic [7:0]  e_if;
    logic [7:0]  e_ie;
    logic        e_req;
    logic [15:0] e_vec;
    logic        e_halt;
    logic        e_wake;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] src, input logic [7:0] wdata,
                              input logic ifw, input logic iew, input ctl_op_t op,
                              input logic valid, input logic ack, input logic done,
                              input logic [7:0] e_if, input logic [7:0] e_ie,
                              input logic e_req, input logic [15:0] e_vec,
                              input logic e_halt, input logic e_wake);
    vec_t v;
    v.src = src; v.wdata = wdata; v.ifw = ifw; v.iew = iew; v.op = op;
    v.valid = valid; v.ack = ack; v.done = done;
    v.e_if = e_if; v.e_ie = e_ie; v.e_req = e_req; v.e_vec = e_vec;
    v.e_halt = e_halt; v.e_wake = e_wake;
    return v;
  endfunction

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic [4:0] src, input logic [7:0] wdata,
                               input logic ifw, input logic iew, input ctl_op_t op,
                               input logic valid, input logic ack, input logic done);
    irq_src   = src;
    reg_wdata = wdata;
    if_wr     = ifw;
    ie_wr     = iew;
    ctl_op    = op;
    ctl_valid = valid;
    int_ack   = ack;
    int_done  = done;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_if,
                             input logic [7:0] e_ie, input logic e_req,
                             input logic [15:0] e_vec, input logic e_halt,
                             input logic e_wake);
    checks++;
    if (if_rdata !== e_if || ie_rdata !== e_ie || int_req !== e_req ||
        int_vector !== e_vec || halted !== e_halt || wake !== e_wake) begin
      errors++;
      $display("[TB] FAIL %s: got if=%h ie=%h req=%b vec=%h halted=%b wake=%b, expected if=%h ie=%h req=%b vec=%h halted=%b wake=%b",
               name, if_rdata, ie_rdata, int_req, int_vector, halted, wake,
               e_if, e_ie, e_req, e_vec, e_halt, e_wake);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_DISP = 2;

  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_ime, m_eip, m_wake;
  int         m_mode, m_idx;

  function automatic int lowestSet(input logic [4:0] p);
    int r = -1;
    for (int i = 4; i >= 0; i--) if (p[i]) r = i;
    return r;
  endfunction

  task automatic modelReset();
    m_if = '0; m_ie = '0; m_ime = 1'b0; m_eip = 1'b0; m_wake = 1'b0;
    m_mode = M_RUN; m_idx = 0;
  endtask

  task automatic modelStep(input logic [4:0] src, input logic [7:0] wdata,
                           input logic ifw, input logic iew, input ctl_op_t op,
                           input logic valid, input logic ack, input logic done);
    logic [4:0] pend;
    logic [4:0] clr;
    logic       req;
    int         win;
    pend   = m_ie[4:0] & m_if;
    win    = lowestSet(pend);
    req    = (m_mode == M_RUN) && m_ime && !m_eip && (pend != 0);
    clr    = '0;
    m_wake = 1'b0;
    if (m_mode == M_RUN) begin
      if (valid) begin
        if (op == CTL_DI) begin
          m_ime = 1'b0;
          m_eip = 1'b0;
        end else begin
          if (m_eip) begin
            m_ime = 1'b1;
            m_eip = 1'b0;
          end else if (op == CTL_EI && !m_ime) begin
            m_eip = 1'b1;
          end
          if (op == CTL_RETI) m_ime = 1'b1;
          if (op == CTL_HALT && pend == 0) m_mode = M_HALT;
        end
      end
      if (ack && req) begin
        clr    = 5'(1 << win);
        m_idx  = win;
        m_ime  = 1'b0;
        m_mode = M_DISP;
      end
    end else if (m_mode == M_HALT) begin
      if (pend != 0) begin
        m_mode = M_RUN;
        m_wake = 1'b1;
      end
    end else begin
      if (done) m_mode = M_RUN;
    end
    m_if = ((ifw ? wdata[4:0] : m_if) & ~clr) | src;
    if (iew) m_ie = wdata;
  endtask

  task automatic checkModel(input string name);
    logic        e_req;
    logic [15:0] e_vec;
    e_req = (m_mode == M_RUN) && m_ime && !m_eip && ((m_ie[4:0] & m_if) != 0);
    e_vec = (m_mode == M_DISP) ? 16'(64 + 8 * m_idx) : 16'h0000;
    checkOutput(name, {3'b111, m_if}, m_ie, e_req, e_vec, m_mode == M_HALT, m_wake);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(5'd0, 8'd0, 1'b0, 1'b0, CTL_NOP, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_src = '0; reg_wdata = '0; if_wr = 1'b0; ie_wr = 1'b0;
    ctl_op = CTL_NOP; ctl_valid = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 8'hE0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // src, wdata, if_wr, ie_wr, op, valid, ack, done | if, ie, req, vec, halted, wake
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE0, 8'h00, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h1F, 0, 1, CTL_NOP,  0, 0, 0, 8'hE0, 8'h1F, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_RETI, 1, 0, 0, 8'hE0, 8'h1F, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h14, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hF4, 8'h1F, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 1, 0, 8'hF0, 8'h1F, 0, 16'h0050, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hF0, 8'h1F, 0, 16'h0050, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 1, 8'hF0, 8'h1F, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h01, 8'h00, 1, 0, CTL_NOP,  0, 0, 0, 8'hE1, 8'h1F, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h01, 0, 1, CTL_NOP,  0, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_EI,   1, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  1, 0, 0, 8'hE1, 8'h01, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 1, 0, 8'hE0, 8'h01, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 1, 8'hE0, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h01, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_EI,   1, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_DI,   1, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  1, 0, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 1, 0, 8'hE1, 8'h01, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h04, 0, 1, CTL_NOP,  0, 0, 0, 8'hE1, 8'h04, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 1, 0, CTL_NOP,  0, 0, 0, 8'hE0, 8'h04, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_HALT, 1, 0, 0, 8'hE0, 8'h04, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE0, 8'h04, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(5'h04, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE4, 8'h04, 0, 16'h0000, 1, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE4, 8'h04, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0, 8'hE4, 8'h04, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(5'h00, 8'h00, 0, 0, CTL_HALT, 1, 0, 0, 8'hE4, 8'h04, 0, 16'h0000, 0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].src, vecs[i].wdata, vecs[i].ifw, vecs[i].iew,
                    vecs[i].op, vecs[i].valid, vecs[i].ack, vecs[i].done);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_if, vecs[i].e_ie, vecs[i].e_req,
                  vecs[i].e_vec, vecs[i].e_halt, vecs[i].e_wake);
    end

    // Asynchronous reset in the middle of a dispatch.
    doReset();
    applyStimulus(5'h00, 8'h01, 0, 1, CTL_NOP,  0, 0, 0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_RETI, 1, 0, 0);
    applyStimulus(5'h01, 8'h00, 0, 0, CTL_NOP,  0, 0, 0);
    checkOutput("pre_ack", 8'hE1, 8'h01, 1'b1, 16'h0000, 1'b0, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 1, 0);
    checkOutput("dispatch", 8'hE0, 8'h01, 1'b0, 16'h0040, 1'b0, 1'b0);
    int_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 8'hE0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(5'h00, 8'h01, 0, 1, CTL_NOP,  0, 0, 0);
    applyStimulus(5'h01, 8'h00, 0, 0, CTL_NOP,  0, 0, 0);
    checkOutput("post_rst_ime0", 8'hE1, 8'h01, 1'b0, 16'h0000, 1'b0, 1'b0);

    // HALT with IME set: request must be up in the first cycle after wake.
    applyStimulus(5'h00, 8'h00, 1, 0, CTL_NOP,  0, 0, 0);
    applyStimulus(5'h00, 8'h02, 0, 1, CTL_NOP,  0, 0, 0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_RETI, 1, 0, 0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_HALT, 1, 0, 0);
    checkOutput("halt_ime1", 8'hE0, 8'h02, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(5'h02, 8'h00, 0, 0, CTL_DI,   1, 0, 0);
    checkOutput("halt_irq", 8'hE2, 8'h02, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 0);
    checkOutput("wake_req", 8'hE2, 8'h02, 1'b1, 16'h0000, 1'b0, 1'b1);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 1, 0);
    checkOutput("wake_ack", 8'hE0, 8'h02, 1'b0, 16'h0048, 1'b0, 1'b0);
    applyStimulus(5'h00, 8'h00, 0, 0, CTL_NOP,  0, 0, 1);
    checkOutput("wake_done", 8'hE0, 8'h02, 1'b0, 16'h0000, 1'b0, 1'b0);

    // Randomized traffic against the reference model.
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] r_src;
      logic [7:0] r_wd;
      logic       r_ifw, r_iew, r_val, r_ack, r_done;
      ctl_op_t    r_op;
      r_src  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      r_wd   = 8'($urandom);
      r_ifw  = ($urandom_range(0, 15) == 0);
      r_iew  = ($urandom_range(0, 15) == 0);
      r_val  = ($urandom_range(0, 2) == 0);
      r_op   = ctl_op_t'($urandom_range(0, 4));
      r_ack  = ($urandom_range(0, 1) == 0);
      r_done = ($urandom_range(0, 3) == 0);
      modelStep(r_src, r_wd, r_ifw, r_iew, r_op, r_val, r_ack, r_done);
      applyStimulus(r_src, r_wd, r_ifw, r_iew, r_op, r_val, r_ack, r_done);
      checkModel($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
